// File: rtl/mw_pipe_reg_if.sv
// mw_pipe_reg_if
//   Bundle between the memory stage, the M/W pipeline register and the
//   writeback stage.
//   Build option: LOAD_EXT_EN (see mw_pipe_reg.sv) changes only what the
//   register does with DMreadM. It does not change this bundle.
//
//   master : memory-stage side. Drives stall/flush and the M bundle, and
//            observes the W bundle.
//   slave  : the pipeline register itself.
//
//   Signals
//     stall, flush                     hazard control into the register
//     Instr_M, PC_M, A3M, ALUoutM,     M-stage result bundle
//     DMreadM
//     Instr_W, PC_W, A3W, ALUoutW,     registered W-stage bundle
//     DMread
//     valid_W                          W holds a real instruction
//     retire_cnt                       retired-instruction counter
interface mw_pipe_reg_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             flush;
  logic [31:0]      Instr_M;
  logic [31:0]      PC_M;
  logic [4:0]       A3M;
  logic [31:0]      ALUoutM;
  logic [31:0]      DMreadM;

  logic [31:0]      Instr_W;
  logic [31:0]      PC_W;
  logic [4:0]       A3W;
  logic [31:0]      ALUoutW;
  logic [31:0]      DMread;
  logic             valid_W;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output stall, flush, Instr_M, PC_M, A3M, ALUoutM, DMreadM,
    input  Instr_W, PC_W, A3W, ALUoutW, DMread, valid_W, retire_cnt
  );

  modport slave (
    input  stall, flush, Instr_M, PC_M, A3M, ALUoutM, DMreadM,
    output Instr_W, PC_W, A3W, ALUoutW, DMread, valid_W, retire_cnt
  );
endinterface

// File: rtl/mw_pipe_reg.sv
// mw_pipe_reg
//   M/W pipeline register. It captures the memory-stage result bundle on
//   each rising edge and presents it to the writeback stage. It can hold
//   its contents (stall), load a bubble (flush), track whether W holds a
//   real instruction (valid_W), and count instructions that leave W.
//
//   Build option LOAD_EXT_EN
//     defined   : DMread loads byte/half/word extended load data. The
//                 opcode comes from Instr_M[31:26] and the byte offset
//                 from ALUoutM[1:0].
//     undefined : DMread loads DMreadM unmodified.
//
//   Parameters
//     PC_RST   PC value presented on PC_W after reset or flush
//     CNT_W    width of the retire counter
//
//   Ports
//     clk      rising-edge clock
//     reset    synchronous, active-low reset
//     bus      mw_pipe_reg_if.slave. Carries stall/flush, the M inputs
//              and the W outputs.
//
//   Every output comes straight from a flop. No combinational path
//   runs from any input to any output.
module mw_pipe_reg #(
  parameter logic [31:0] PC_RST = 32'h0000_3000,
  parameter int          CNT_W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  mw_pipe_reg_if.slave  bus
);

  logic [31:0]      r_instr;
  logic [31:0]      r_pc;
  logic [4:0]       r_a3;
  logic [31:0]      r_alu;
  logic [31:0]      r_dm;
  logic             r_valid;
  logic [CNT_W-1:0] r_retire_cnt;

  logic [31:0]      w_dm_load;
  logic             w_hold;
  logic             w_retire;

`ifdef LOAD_EXT_EN
  function automatic logic [31:0] load_ext(
    input logic [31:0] word,
    input logic [5:0]  op,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    // off[0] is ignored for halfwords. A misaligned lh reads the half
    // that contains the addressed byte.
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      6'b100000: load_ext = {{24{b[7]}}, b};
      6'b100100: load_ext = {24'h0, b};
      6'b100001: load_ext = {{16{h[15]}}, h};
      6'b100101: load_ext = {16'h0, h};
      default:   load_ext = word;
    endcase
  endfunction

  assign w_dm_load = load_ext(bus.DMreadM, bus.Instr_M[31:26], bus.ALUoutM[1:0]);
`else
  assign w_dm_load = bus.DMreadM;
`endif

  // Flush overrides stall, so a flush edge always moves W forward.
  assign w_hold   = bus.stall & ~bus.flush;
  // The instruction currently in W leaves on every edge that W is not held.
  assign w_retire = r_valid & ~w_hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instr      <= 32'h0;
      r_pc         <= PC_RST;
      r_a3         <= 5'd0;
      r_alu        <= 32'h0;
      r_dm         <= 32'h0;
      r_valid      <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      if (w_retire)
        r_retire_cnt <= r_retire_cnt + 1'b1;

      if (bus.flush) begin
        r_instr <= 32'h0;
        r_pc    <= PC_RST;
        r_a3    <= 5'd0;
        r_alu   <= 32'h0;
        r_dm    <= 32'h0;
        r_valid <= 1'b0;
      end else if (!bus.stall) begin
        r_instr <= bus.Instr_M;
        r_pc    <= bus.PC_M;
        r_a3    <= bus.A3M;
        r_alu   <= bus.ALUoutM;
        r_dm    <= w_dm_load;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.Instr_W    = r_instr;
  assign bus.PC_W       = r_pc;
  assign bus.A3W        = r_a3;
  assign bus.ALUoutW    = r_alu;
  assign bus.DMread     = r_dm;
  assign bus.valid_W    = r_valid;
  assign bus.retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mw_pipe_reg.sv
module tb_mw_pipe_reg;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  mw_pipe_reg_if #(.CNT_W(32)) bus  ();
  mw_pipe_reg_if #(.CNT_W(3))  bus3 ();

  mw_pipe_reg #(.PC_RST(32'h0000_3000), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Narrow counter instance so that counter wrap is reachable in a short run.
  mw_pipe_reg #(.PC_RST(32'h0000_3000), .CNT_W(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge. Inputs may be changed and outputs sampled afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [4:0] a3, input logic [31:0] alu,
                       input logic [31:0] dm);
    bus.Instr_M = instr;
    bus.PC_M    = pc;
    bus.A3M     = a3;
    bus.ALUoutM = alu;
    bus.DMreadM = dm;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    bus.stall  = 1'b0;
    bus.flush  = 1'b0;
    set_m(32'hFFFF_FFFF, 32'h0000_9999, 5'd31, 32'hAAAA_AAAA, 32'h5555_5555);
    bus3.stall = 1'b1;
    bus3.flush = 1'b0;
    bus3.Instr_M = 32'h0; bus3.PC_M = 32'h0000_4000; bus3.A3M = 5'd1;
    bus3.ALUoutM = 32'h0; bus3.DMreadM = 32'h0;
    tick();
    tick();
    chk32("reset PC_W",       bus.PC_W,       32'h0000_3000);
    chk32("reset Instr_W",    bus.Instr_W,    32'h0);
    chk32("reset A3W",        {27'h0, bus.A3W}, 32'h0);
    chk32("reset ALUoutW",    bus.ALUoutW,    32'h0);
    chk32("reset DMread",     bus.DMread,     32'h0);
    chk32("reset valid_W",    {31'h0, bus.valid_W}, 32'h0);
    chk32("reset retire_cnt", bus.retire_cnt, 32'h0);
  endtask

  task automatic test_load();
    reset = 1'b1;
    set_m(32'h0000_0020, 32'h0000_3004, 5'd8, 32'h0000_1234, 32'hDEAD_BEEF);
    tick();
    chk32("load PC_W",       bus.PC_W,       32'h0000_3004);
    chk32("load ALUoutW",    bus.ALUoutW,    32'h0000_1234);
    chk32("load A3W",        {27'h0, bus.A3W}, 32'd8);
    chk32("load Instr_W",    bus.Instr_W,    32'h0000_0020);
    chk32("load DMread",     bus.DMread,     32'hDEAD_BEEF);
    chk32("load valid_W",    {31'h0, bus.valid_W}, 32'h1);
    chk32("load retire_cnt", bus.retire_cnt, 32'h0);
    // A nop with $0 destination still counts as a real instruction.
    set_m(32'h0000_0000, 32'h0000_3008, 5'd0, 32'h0000_5678, 32'h0000_0011);
    tick();
    chk32("nop PC_W",        bus.PC_W,       32'h0000_3008);
    chk32("nop Instr_W",     bus.Instr_W,    32'h0);
    chk32("nop A3W",         {27'h0, bus.A3W}, 32'h0);
    chk32("nop valid_W",     {31'h0, bus.valid_W}, 32'h1);
    chk32("nop retire_cnt",  bus.retire_cnt, 32'h1);
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_m(32'h1111_0000 + i, 32'h0000_5000 + 4 * i, 5'd20 + 5'(i),
            32'h0BAD_0000 + i, 32'hCAFE_0000 + i);
      tick();
      chk32("stall PC_W",       bus.PC_W,       32'h0000_3008);
      chk32("stall ALUoutW",    bus.ALUoutW,    32'h0000_5678);
      chk32("stall A3W",        {27'h0, bus.A3W}, 32'h0);
      chk32("stall DMread",     bus.DMread,     32'h0000_0011);
      chk32("stall valid_W",    {31'h0, bus.valid_W}, 32'h1);
      chk32("stall retire_cnt", bus.retire_cnt, 32'h1);
    end
    bus.stall = 1'b0;
    set_m(32'h0000_0020, 32'h0000_300C, 5'd9, 32'h0000_0ABC, 32'h0123_4567);
    tick();
    chk32("unstall PC_W",       bus.PC_W,       32'h0000_300C);
    chk32("unstall A3W",        {27'h0, bus.A3W}, 32'd9);
    chk32("unstall DMread",     bus.DMread,     32'h0123_4567);
    chk32("unstall retire_cnt", bus.retire_cnt, 32'h2);
  endtask

  task automatic test_flush_stall();
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    set_m(32'h0000_0020, 32'h0000_3010, 5'd10, 32'h0000_0001, 32'h0000_0002);
    tick();
    chk32("flush Instr_W",    bus.Instr_W,    32'h0);
    chk32("flush valid_W",    {31'h0, bus.valid_W}, 32'h0);
    chk32("flush PC_W",       bus.PC_W,       32'h0000_3000);
    chk32("flush A3W",        {27'h0, bus.A3W}, 32'h0);
    chk32("flush ALUoutW",    bus.ALUoutW,    32'h0);
    chk32("flush DMread",     bus.DMread,     32'h0);
    chk32("flush retire_cnt", bus.retire_cnt, 32'h3);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    tick();
    chk32("post-flush PC_W",       bus.PC_W,       32'h0000_3010);
    chk32("post-flush valid_W",    {31'h0, bus.valid_W}, 32'h1);
    chk32("post-flush retire_cnt", bus.retire_cnt, 32'h3);
    bus.stall = 1'b1;
    reset     = 1'b0;
    tick();
    chk32("reset-in-stall retire_cnt", bus.retire_cnt, 32'h0);
    chk32("reset-in-stall valid_W",    {31'h0, bus.valid_W}, 32'h0);
    chk32("reset-in-stall PC_W",       bus.PC_W,       32'h0000_3000);
    reset     = 1'b1;
    bus.stall = 1'b0;
  endtask

  task automatic test_wrap();
    bus3.stall = 1'b0;
    tick();
    chk32("wrap first valid", {31'h0, bus3.valid_W}, 32'h1);
    chk32("wrap first cnt",   {29'h0, bus3.retire_cnt}, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    chk32("wrap max cnt",     {29'h0, bus3.retire_cnt}, 32'h7);
    tick();
    chk32("wrap to zero",     {29'h0, bus3.retire_cnt}, 32'h0);
    tick();
    chk32("wrap after zero",  {29'h0, bus3.retire_cnt}, 32'h1);
    bus3.stall = 1'b1;
  endtask

  task automatic test_load_ext();
    logic [5:0]  op  [7];
    logic [1:0]  off [7];
    logic [31:0] ext [7];
    op[0] = 6'b100000; off[0] = 2'd3; ext[0] = 32'hFFFF_FF80;
    op[1] = 6'b100100; off[1] = 2'd1; ext[1] = 32'h0000_007F;
    op[2] = 6'b100001; off[2] = 2'd2; ext[2] = 32'hFFFF_80FF;
    op[3] = 6'b100101; off[3] = 2'd0; ext[3] = 32'h0000_7F01;
    op[4] = 6'b100011; off[4] = 2'd2; ext[4] = 32'h80FF_7F01;
    op[5] = 6'b100001; off[5] = 2'd3; ext[5] = 32'hFFFF_80FF;
    op[6] = 6'b000000; off[6] = 2'd0; ext[6] = 32'h80FF_7F01;
    for (int i = 0; i < 7; i++) begin
      set_m({op[i], 26'h0}, 32'h0000_3100 + 4 * i, 5'd3,
            32'h1000_0000 | {30'h0, off[i]}, 32'h80FF_7F01);
      tick();
`ifdef LOAD_EXT_EN
      chk32("load-ext DMread", bus.DMread, ext[i]);
`else
      chk32("raw DMread", bus.DMread, 32'h80FF_7F01);
      if (ext[i] === 32'h0) $display("unexpected table entry");
`endif
      chk32("load-ext ALUoutW", bus.ALUoutW, 32'h1000_0000 | {30'h0, off[i]});
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_wrap();
    test_load_ext();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
